// File: rtl/hart_sched_pkg.sv
// Shared constants, state encodings and enable levels for the fetch-stage hart scheduler.
package hart_sched_pkg;

  localparam int unsigned HART_NUM  = 4;
  localparam int unsigned HART_ID_W = 2;
  localparam int unsigned CNT_W     = 32;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    HART_IDLE = 2'b00,
    HART_RUN  = 2'b01,
    HART_MISS = 2'b10
  } hart_state_e;

endpackage

// File: rtl/hart_sched_if.sv
// Bundle between hart control / I-cache miss path / IF stage and the scheduler.
interface hart_sched_if #(
  parameter int unsigned HART_NUM  = hart_sched_pkg::HART_NUM,
  parameter int unsigned HART_ID_W = hart_sched_pkg::HART_ID_W
);

  logic                 stall;
  logic [HART_NUM-1:0]  hart_act;
  logic                 cache_miss;
  logic [HART_ID_W-1:0] cm_hart_id;
  logic                 refill_done;
  logic [HART_ID_W-1:0] rf_hart_id;
  logic [HART_ID_W-1:0] hart_id;
  logic                 issue_en;
  logic [HART_NUM-1:0]  run_mask;
  logic [HART_NUM-1:0]  miss_mask;

  modport master (
    output stall, hart_act, cache_miss, cm_hart_id, refill_done, rf_hart_id,
    input  hart_id, issue_en, run_mask, miss_mask
  );

  modport slave (
    input  stall, hart_act, cache_miss, cm_hart_id, refill_done, rf_hart_id,
    output hart_id, issue_en, run_mask, miss_mask
  );

endinterface

// File: rtl/hart_sched_rr_pick.sv
// Combinational round-robin find-first: first set request at or after start, wrapping.
module hart_sched_rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] grant_c,
  output logic         found_c
);

  // Walk N positions from start; index arithmetic wraps naturally since N is 2**W.
  always_comb begin
    logic [W-1:0] idx;
    grant_c = '0;
    found_c = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = start + W'(k);
      if (!found_c && req[idx]) begin
        grant_c = idx;
        found_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hart_sched.sv
// Round-robin fetch hart scheduler with per-hart IDLE/RUN/MISS tracking.
// Optional feature macro: HART_SCHED_STAT_EN adds per-hart 32-bit issue counters (issue_cnt).
module hart_sched
  import hart_sched_pkg::*;
#(
  parameter int unsigned HART_NUM  = hart_sched_pkg::HART_NUM,
  parameter int unsigned HART_ID_W = hart_sched_pkg::HART_ID_W
) (
  input  logic clk,
  input  logic reset_n,
`ifdef HART_SCHED_STAT_EN
  output logic [HART_NUM*CNT_W-1:0] issue_cnt,
`endif
  hart_sched_if.slave bus
);

  logic [HART_NUM-1:0]  miss_oh_c;
  logic [HART_NUM-1:0]  refill_oh_c;
  logic [HART_NUM-1:0]  run_c;
  logic [HART_NUM-1:0]  missing_c;
  logic [HART_NUM-1:0]  elig_c;
  logic [HART_ID_W-1:0] start_c;
  logic [HART_ID_W-1:0] pick_grant_c;
  logic                 pick_found_c;

  logic [HART_ID_W-1:0] hart_id_q, hart_id_d;
  logic                 issue_en_q, issue_en_d;

  // One-hot views of this cycle's miss and refill events.
  always_comb begin
    miss_oh_c   = '0;
    refill_oh_c = '0;
    if (bus.cache_miss)  miss_oh_c   = HART_NUM'(1) << bus.cm_hart_id;
    if (bus.refill_done) refill_oh_c = HART_NUM'(1) << bus.rf_hart_id;
  end

  for (genvar i = 0; i < HART_NUM; i++) begin : g_hart
    localparam hart_state_e RST_ST = (i == 0) ? HART_RUN : HART_IDLE;

    hart_state_e state_q, state_d;

    // Per-hart run-state register; hart 0 comes out of reset already running.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= RST_ST;
      else          state_q <= state_d;
    end

    // Next state: deactivation dominates, and a same-cycle miss beats a refill.
    always_comb begin
      state_d = state_q;
      if (!bus.hart_act[i]) begin
        state_d = HART_IDLE;
      end else begin
        case (state_q)
          HART_IDLE: state_d = HART_RUN;
          HART_RUN:  if (miss_oh_c[i]) state_d = HART_MISS;
          HART_MISS: if (refill_oh_c[i] && !miss_oh_c[i]) state_d = HART_RUN;
          default:   state_d = HART_IDLE;
        endcase
      end
    end

    assign run_c[i]     = (state_q == HART_RUN);
    assign missing_c[i] = (state_q == HART_MISS);
  end

  // A hart missing right now must not be handed the next fetch slot.
  assign elig_c  = run_c & ~miss_oh_c;
  assign start_c = hart_id_q + HART_ID_W'(1);

  hart_sched_rr_pick #(
    .N (HART_NUM),
    .W (HART_ID_W)
  ) u_rr_pick (
    .req     (elig_c),
    .start   (start_c),
    .grant_c (pick_grant_c),
    .found_c (pick_found_c)
  );

  // Selection advances only when unstalled; with nothing eligible the id is kept.
  always_comb begin
    hart_id_d  = hart_id_q;
    issue_en_d = issue_en_q;
    if (!bus.stall) begin
      issue_en_d = pick_found_c ? ENABLE : DISABLE;
      if (pick_found_c) hart_id_d = pick_grant_c;
    end
  end

  // Selection output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hart_id_q  <= '0;
      issue_en_q <= DISABLE;
    end else begin
      hart_id_q  <= hart_id_d;
      issue_en_q <= issue_en_d;
    end
  end

  assign bus.hart_id   = hart_id_q;
  assign bus.issue_en  = issue_en_q;
  assign bus.run_mask  = run_c;
  assign bus.miss_mask = missing_c;

`ifdef HART_SCHED_STAT_EN
  for (genvar i = 0; i < HART_NUM; i++) begin : g_stat
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count fetches actually consumed: the presented hart on an unstalled edge.
    always_comb begin
      cnt_d = cnt_q;
      if (!bus.stall && issue_en_q && (hart_id_q == HART_ID_W'(i))) cnt_d = cnt_q + CNT_W'(1);
    end

    // Free-running wrap-around issue counter.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
    end

    assign issue_cnt[CNT_W*i +: CNT_W] = cnt_q;
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_hart_sched.sv
// Randomised, model-checked bench for hart_sched (4 harts), with directed scenarios.
module tb_hart_sched;

  localparam int unsigned HN = 4;
  localparam int unsigned HW = 2;

  logic clk;
  logic reset_n;

  hart_sched_if #(.HART_NUM(HN), .HART_ID_W(HW)) bus ();

`ifdef HART_SCHED_STAT_EN
  logic [HN*32-1:0] issue_cnt;
`endif

  hart_sched #(.HART_NUM(HN), .HART_ID_W(HW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
`ifdef HART_SCHED_STAT_EN
    .issue_cnt (issue_cnt),
`endif
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 0;

  // Stimulus mirror (what the DUT sees)
  logic       st;
  logic [3:0] act;
  logic       cm;
  logic [1:0] cmid;
  logic       rf;
  logic [1:0] rfid;

  // Reference model: sets of running / missing harts, current pick
  bit m_run [4];
  bit m_miss[4];
  int m_id;
  bit m_en;
`ifdef HART_SCHED_STAT_EN
  logic [31:0] m_cnt[4];
`endif

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic [3:0] a, input logic c, input logic [1:0] ci,
                       input logic r, input logic [1:0] ri);
    st = s; act = a; cm = c; cmid = ci; rf = r; rfid = ri;
    bus.stall = s; bus.hart_act = a; bus.cache_miss = c; bus.cm_hart_id = ci;
    bus.refill_done = r; bus.rf_hart_id = ri;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_run[i]  = (i == 0);
      m_miss[i] = 1'b0;
`ifdef HART_SCHED_STAT_EN
      m_cnt[i] = 32'd0;
`endif
    end
    m_id = 0;
    m_en = 1'b0;
  endtask

  task automatic model_step();
    bit el[4];
    bit found;
    int nid;
    for (int i = 0; i < 4; i++) el[i] = m_run[i] && !(cm && (int'(cmid) == i));
`ifdef HART_SCHED_STAT_EN
    if (!st && m_en) m_cnt[m_id] = m_cnt[m_id] + 32'd1;
`endif
    if (!st) begin
      found = 1'b0;
      nid   = m_id;
      for (int k = 1; k <= 4; k++) begin
        int j;
        j = (m_id + k) % 4;
        if (!found && el[j]) begin
          found = 1'b1;
          nid   = j;
        end
      end
      m_id = nid;
      m_en = found;
    end
    for (int i = 0; i < 4; i++) begin
      bit mi, ri;
      mi = cm && (int'(cmid) == i);
      ri = rf && (int'(rfid) == i);
      if (!act[i]) begin
        m_run[i] = 1'b0; m_miss[i] = 1'b0;
      end else if (!m_run[i] && !m_miss[i]) begin
        m_run[i] = 1'b1;
      end else if (m_run[i] && mi) begin
        m_run[i] = 1'b0; m_miss[i] = 1'b1;
      end else if (m_miss[i] && ri && !mi) begin
        m_run[i] = 1'b1; m_miss[i] = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    logic [3:0] er, em;
    for (int i = 0; i < 4; i++) begin
      er[i] = m_run[i];
      em[i] = m_miss[i];
    end
    chk("hart_id",   32'(bus.hart_id),   32'(m_id));
    chk("issue_en",  32'(bus.issue_en),  32'(m_en));
    chk("run_mask",  32'(bus.run_mask),  32'(er));
    chk("miss_mask", 32'(bus.miss_mask), 32'(em));
`ifdef HART_SCHED_STAT_EN
    for (int i = 0; i < 4; i++) chk("issue_cnt", issue_cnt[32*i +: 32], m_cnt[i]);
`endif
  endtask

  // Model follows the same clock and asynchronous reset as the DUT
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else          model_step();
  end

  // Compare process: outputs sampled mid-cycle
  always @(negedge clk) begin
    if (cmp_on) compare_all();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs(input logic [3:0] a);
    drive(1'b0, a, 1'b0, 2'd0, 1'b0, 2'd0);
  endtask

  int exp_seq[6];

  initial begin
    reset_n = 1'b0;
    model_reset();
    idle_inputs(4'b0000);
    step();
    step();
    cmp_on = 1;
    chk("rst_hart_id",   32'(bus.hart_id),   32'd0);
    chk("rst_issue_en",  32'(bus.issue_en),  32'd0);
    chk("rst_run_mask",  32'(bus.run_mask),  32'b0001);
    chk("rst_miss_mask", 32'(bus.miss_mask), 32'b0000);

    // All harts activated: hart 0 first, then newcomers in rotation
    reset_n = 1'b1;
    idle_inputs(4'b1111);
    exp_seq = '{0, 1, 2, 3, 0, 1};
    for (int e = 0; e < 6; e++) begin
      step();
      chk("rr_seq_id", 32'(bus.hart_id), 32'(exp_seq[e]));
      chk("rr_seq_en", 32'(bus.issue_en), 32'd1);
    end

    // Miss on hart 2: skipped at once, back two edges after refill
    drive(1'b0, 4'b1111, 1'b1, 2'd2, 1'b0, 2'd0);
    step();
    chk("miss2_id",   32'(bus.hart_id),   32'd3);
    chk("miss2_mask", 32'(bus.miss_mask), 32'b0100);
    idle_inputs(4'b1111);
    repeat (3) step();
    drive(1'b0, 4'b1111, 1'b0, 2'd0, 1'b1, 2'd2);
    step();
    chk("refill2_run", 32'(bus.run_mask), 32'b1111);
    idle_inputs(4'b1111);
    step();
    step();
    chk("refill2_pick", 32'(bus.hart_id), 32'd2);

    // Same-cycle miss and refill on hart 1: miss wins
    drive(1'b0, 4'b1111, 1'b1, 2'd1, 1'b1, 2'd1);
    step();
    chk("mr1_mask", 32'(bus.miss_mask), 32'b0010);
    idle_inputs(4'b1111);
    repeat (5) step();
    drive(1'b0, 4'b1111, 1'b0, 2'd0, 1'b1, 2'd1);
    step();
    idle_inputs(4'b1111);
    repeat (3) step();

    // Only hart 0 running, and it misses
    idle_inputs(4'b0001);
    repeat (4) step();
    drive(1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 2'd0);
    step();
    chk("solo_miss_en", 32'(bus.issue_en), 32'd0);
    chk("solo_miss_id", 32'(bus.hart_id),  32'd0);
    idle_inputs(4'b0001);
    repeat (2) step();
    chk("solo_wait_en", 32'(bus.issue_en), 32'd0);
    drive(1'b0, 4'b0001, 1'b0, 2'd0, 1'b1, 2'd0);
    step();
    chk("solo_rf_en",  32'(bus.issue_en), 32'd0);
    chk("solo_rf_run", 32'(bus.run_mask), 32'b0001);
    idle_inputs(4'b0001);
    step();
    chk("solo_back_en", 32'(bus.issue_en), 32'd1);
    chk("solo_back_id", 32'(bus.hart_id),  32'd0);

    // Stall for 5 cycles with a miss on hart 3 arriving during it
    idle_inputs(4'b1111);
    repeat (3) step();
    drive(1'b1, 4'b1111, 1'b0, 2'd0, 1'b0, 2'd0);
    step();
    drive(1'b1, 4'b1111, 1'b1, 2'd3, 1'b0, 2'd0);
    step();
    chk("stall_miss3", 32'(bus.miss_mask[3]), 32'd1);
    drive(1'b1, 4'b1111, 1'b0, 2'd0, 1'b0, 2'd0);
    repeat (3) step();
    idle_inputs(4'b1111);
    repeat (6) step();

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] a;
      logic [1:0] rid;
      a = act;
      for (int i = 0; i < 4; i++) begin
        if (a[i]) a[i] = ($urandom_range(0, 99) >= 3);
        else      a[i] = ($urandom_range(0, 99) < 30);
      end
      rid = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 4; i++) if (m_miss[i]) rid = 2'(i);
      end
      drive(($urandom_range(0, 99) < 20), a, ($urandom_range(0, 99) < 25),
            2'($urandom_range(0, 3)), ($urandom_range(0, 99) < 30), rid);
      step();
    end

    // Asynchronous reset mid-cycle, no clock edge needed
    idle_inputs(4'b1111);
    repeat (3) step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_hart_id",   32'(bus.hart_id),   32'd0);
    chk("async_issue_en",  32'(bus.issue_en),  32'd0);
    chk("async_run_mask",  32'(bus.run_mask),  32'b0001);
    chk("async_miss_mask", 32'(bus.miss_mask), 32'b0000);
    step();
    reset_n = 1'b1;
    idle_inputs(4'b1111);
    repeat (4) step();

`ifdef HART_SCHED_STAT_EN
    // Two harts sharing 100 unstalled fetch slots
    reset_n = 1'b0;
    #1;
    step();
    reset_n = 1'b1;
    idle_inputs(4'b0011);
    repeat (101) step();
    chk("stat_cnt0", issue_cnt[31:0],  32'd50);
    chk("stat_cnt1", issue_cnt[63:32], 32'd50);
`endif

    @(negedge clk);
    cmp_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
